dffram_march_bist: RTL and testbench

//   March C- built-in self-test engine and port mux for a parametrised single-port DFFRAM (WSIZE bytes x BANKS*16 words).

---
 rtl/dffram_march_bist_pkg.sv | 32 +++
 rtl/dffram_march_bist_if.sv | 16 +
 rtl/dffram_bist_addr_gen.sv | 34 +++
 rtl/dffram_march_bist.sv | 152 +++++++++++++++
 tb/tb_dffram_march_bist.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dffram_march_bist_pkg.sv
// Shared encodings for the DFFRAM March C- BIST: element enum, FSM states, backgrounds
// and per-element helpers.
package dffram_pkg;
  typedef enum logic [2:0] {E0 = 3'd0, E1, E2, E3, E4, E5} march_elem_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_RDW    = 3'd3;
  localparam logic [2:0] S_CMP_WR = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;

  function automatic int awidth(input int banks);
    return $clog2(banks) + 4;
  endfunction

  function automatic logic elem_down(input march_elem_e e);
    return (e == E3) || (e == E4);
  endfunction

  // Background each element expects on its read (E0 never reads).
  function automatic logic elem_rd_bg(input march_elem_e e);
    return ((e == E2) || (e == E4)) ? BG1 : BG0;
  endfunction

  function automatic logic elem_wr_bg(input march_elem_e e);
    return ((e == E1) || (e == E3)) ? BG1 : BG0;
  endfunction
endpackage

// File: rtl/dffram_march_bist_if.sv
// Single-port DFFRAM bus; master drives the request, slave returns read data.
interface dffram_march_bist_if #(
  parameter int WSIZE  = 4,
  parameter int AWIDTH = 9
);
  localparam int DW = WSIZE * 8;

  logic [WSIZE-1:0]  WE0;
  logic              EN0;
  logic [AWIDTH-1:0] A0;
  logic [DW-1:0]     Di0;
  logic [DW-1:0]     Do0;

  modport master (output WE0, EN0, A0, Di0, input Do0);
  modport slave  (input WE0, EN0, A0, Di0, output Do0);
endinterface

// File: rtl/dffram_bist_addr_gen.sv
// Up/down March address counter: load to the start of a direction, step, flag the last address.
module dffram_bist_addr_gen #(
  parameter int AWIDTH = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_step,
  input  logic              i_down,
  output logic [AWIDTH-1:0] o_addr,
  output logic              o_last
);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= '0;
    else if (i_load)
      r_addr <= i_load_down ? LAST : '0;
    else if (i_step) begin
      if (i_down)
        r_addr <= r_addr - AWIDTH'(1);
      else
        r_addr <= (r_addr == LAST) ? '0 : r_addr + AWIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == '0) : (r_addr == LAST);
endmodule

// File: rtl/dffram_march_bist.sv
// March C- BIST engine and port mux in front of a single-port DFFRAM.
// Define BIST_FAIL_LOG_EN to add FAIL_ADDR/FAIL_ELEM/FAIL_DATA first-mismatch capture.
module dffram_march_bist
  import dffram_pkg::*;
#(
  parameter  int WSIZE  = 4,
  parameter  int BANKS  = 32,
  parameter  int RD_LAT = 1,
  localparam int DW     = WSIZE * 8,
  localparam int AWIDTH = awidth(BANKS),
  localparam int DEPTH  = BANKS * 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  output logic BUSY,
  output logic DONE,
  output logic FAIL,
`ifdef BIST_FAIL_LOG_EN
  output logic [AWIDTH-1:0] FAIL_ADDR,
  output logic [2:0]        FAIL_ELEM,
  output logic [DW-1:0]     FAIL_DATA,
`endif
  dffram_march_bist_if.slave  f_bus,
  dffram_march_bist_if.master ram_bus
);
  localparam int WCW = $clog2(RD_LAT + 1);

  logic [2:0]        r_state, w_state_nxt;
  march_elem_e       r_elem, w_elem_nxt;
  logic [WCW-1:0]    r_wcnt, w_wait_len;
  logic              r_done, r_fail;
  logic              w_load, w_step, w_last, w_start, w_wr, w_mis;
  logic [AWIDTH-1:0] w_addr;
  logic [DW-1:0]     w_exp;

  dffram_bist_addr_gen #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_addr (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_load     (w_load),
    .i_load_down(elem_down(w_elem_nxt)),
    .i_step     (w_step),
    .i_down     (elem_down(r_elem)),
    .o_addr     (w_addr),
    .o_last     (w_last)
  );

  assign BUSY    = (r_state != S_IDLE) && (r_state != S_FIN);
  assign DONE    = r_done;
  assign FAIL    = r_fail;
  assign w_start = (r_state == S_IDLE) && START;
  // E5 compares in the cycle data lands; E1-E4 hold one more cycle and write on compare.
  assign w_wait_len = (r_elem == E5) ? WCW'(RD_LAT - 1) : WCW'(RD_LAT);

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: if (START) begin
        w_state_nxt = S_WR;
        w_elem_nxt  = E0;
        w_load      = 1'b1;
      end
      S_WR: if (w_last) begin
        w_state_nxt = S_RD;
        w_elem_nxt  = E1;
        w_load      = 1'b1;
      end else
        w_step = 1'b1;
      S_RD:  w_state_nxt = (w_wait_len == '0) ? S_CMP_WR : S_RDW;
      S_RDW: if (r_wcnt == w_wait_len) w_state_nxt = S_CMP_WR;
      S_CMP_WR: begin
        if (!w_last) begin
          w_step      = 1'b1;
          w_state_nxt = S_RD;
        end else if (r_elem == E5)
          w_state_nxt = S_FIN;
        else begin
          w_elem_nxt  = march_elem_e'(r_elem + 3'd1);
          w_load      = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr  = (r_state == S_WR) || ((r_state == S_CMP_WR) && (r_elem != E5));
  assign w_exp = {DW{elem_rd_bg(r_elem)}};
  assign w_mis = (r_state == S_CMP_WR) && (ram_bus.Do0 != w_exp);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_elem  <= E0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      if (r_state == S_RD)
        r_wcnt <= WCW'(1);
      else if (r_state == S_RDW)
        r_wcnt <= r_wcnt + WCW'(1);
      if (w_start) begin
        r_done <= 1'b0;
        r_fail <= 1'b0;
      end else begin
        if (w_mis) r_fail <= 1'b1;
        if (w_state_nxt == S_FIN) r_done <= 1'b1;
      end
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [AWIDTH-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic [DW-1:0]     r_fail_data;

  // Only the first mismatch of a run is kept; r_fail still low marks it as first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_data <= '0;
    end else if (w_start) begin
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_data <= '0;
    end else if (w_mis && !r_fail) begin
      r_fail_addr <= w_addr;
      r_fail_elem <= r_elem;
      r_fail_data <= ram_bus.Do0;
    end
  end

  assign FAIL_ADDR = r_fail_addr;
  assign FAIL_ELEM = r_fail_elem;
  assign FAIL_DATA = r_fail_data;
`endif

  // Functional traffic reaches the RAM untouched whenever the BIST is not driving it.
  assign ram_bus.EN0 = BUSY ? 1'b1 : f_bus.EN0;
  assign ram_bus.WE0 = BUSY ? {WSIZE{w_wr}} : f_bus.WE0;
  assign ram_bus.A0  = BUSY ? w_addr : f_bus.A0;
  assign ram_bus.Di0 = BUSY ? {DW{elem_wr_bg(r_elem)}} : f_bus.Di0;
  assign f_bus.Do0   = ram_bus.Do0;
endmodule

// File: tb/tb_dffram_march_bist.sv
// Bench for dffram_march_bist: default build plus a WSIZE=2/BANKS=4/RD_LAT=2 instance, with
// behavioural RAM models, an optional stuck-at cell and an array-based March C- reference.
`timescale 1ns/1ps
module tb_dffram_march_bist;
  localparam int DEPTH1    = 512;
  localparam int DEPTH2    = 64;
  localparam int BUSY1_EXP = DEPTH1 * (1 + 4 * (2 + 1) + 1 + 1);
  localparam int BUSY2_EXP = DEPTH2 * (1 + 4 * (2 + 2) + 1 + 2);
  localparam int LIMIT     = 20000;

  logic CLK = 1'b0, RST_N = 1'b0, START1 = 1'b0, START2 = 1'b0;
  logic BUSY1, DONE1, FAIL1, BUSY2, DONE2, FAIL2;
  int   tests = 0, fails = 0;

  dffram_march_bist_if #(.WSIZE(4), .AWIDTH(9)) f1 (), r1 ();
  dffram_march_bist_if #(.WSIZE(2), .AWIDTH(6)) f2 (), r2 ();

`ifdef BIST_FAIL_LOG_EN
  logic [8:0] FA1; logic [2:0] FE1; logic [31:0] FD1;
  logic [5:0] FA2; logic [2:0] FE2; logic [15:0] FD2;
`endif

  dffram_march_bist dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .BUSY(BUSY1), .DONE(DONE1), .FAIL(FAIL1),
`ifdef BIST_FAIL_LOG_EN
    .FAIL_ADDR(FA1), .FAIL_ELEM(FE1), .FAIL_DATA(FD1),
`endif
    .f_bus(f1), .ram_bus(r1));

  dffram_march_bist #(.WSIZE(2), .BANKS(4), .RD_LAT(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .START(START2), .BUSY(BUSY2), .DONE(DONE2), .FAIL(FAIL2),
`ifdef BIST_FAIL_LOG_EN
    .FAIL_ADDR(FA2), .FAIL_ELEM(FE2), .FAIL_DATA(FD2),
`endif
    .f_bus(f2), .ram_bus(r2));

  always #5 CLK = ~CLK;

  // RAM models: read latency 1 (dut1) and 2 (dut2); dut1 can host one stuck-at cell.
  logic [31:0] mem1 [DEPTH1];
  logic [31:0] q1;
  logic [15:0] mem2 [DEPTH2];
  logic [15:0] q2a, q2b;
  bit fault_en = 1'b0;
  bit fault_val = 1'b0;
  int fault_addr = 0, fault_bit = 0;

  function automatic logic [31:0] merge32(logic [31:0] old, logic [3:0] we, logic [31:0] d, int a);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
    if (fault_en && a == fault_addr) w[fault_bit] = fault_val;
    return w;
  endfunction

  function automatic logic [15:0] merge16(logic [15:0] old, logic [1:0] we, logic [15:0] d);
    logic [15:0] w = old;
    for (int b = 0; b < 2; b++) if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
    return w;
  endfunction

  always @(posedge CLK) if (r1.EN0) begin
    if (r1.WE0 != 4'h0) mem1[r1.A0] <= merge32(mem1[r1.A0], r1.WE0, r1.Di0, int'(r1.A0));
    else                q1 <= mem1[r1.A0];
  end
  assign r1.Do0 = q1;

  always @(posedge CLK) begin
    q2b <= q2a;
    if (r2.EN0) begin
      if (r2.WE0 != 2'h0) mem2[r2.A0] <= merge16(mem2[r2.A0], r2.WE0, r2.Di0);
      else                q2a <= mem2[r2.A0];
    end
  end
  assign r2.Do0 = q2b;

  // March C- over a plain array with the same stuck-at cell; reports the first bad read.
  function automatic void march_ref(input bit fen, input int fa, input int fb, input bit fv,
                                    output bit fail, output int f_addr, output int f_elem,
                                    output logic [31:0] f_data);
    logic [31:0] m [DEPTH1];
    int rd [6] = '{-1, 0, 1, 0, 1, -2};
    int wr [6] = '{ 0, 1, 0, 1, 0, -1};
    bit dn [6] = '{ 0, 0, 0, 1, 1,  0};
    fail = 1'b0; f_addr = 0; f_elem = 0; f_data = '0;
    rd[5] = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH1; k++) begin
        int a;
        logic [31:0] w;
        a = dn[e] ? DEPTH1 - 1 - k : k;
        if (rd[e] >= 0 && m[a] !== ((rd[e] == 1) ? 32'hFFFF_FFFF : 32'h0)) begin
          if (!fail) begin f_addr = a; f_elem = e; f_data = m[a]; end
          fail = 1'b1;
        end
        if (wr[e] >= 0) begin
          w = (wr[e] == 1) ? 32'hFFFF_FFFF : 32'h0;
          if (fen && a == fa) w[fb] = fv;
          m[a] = w;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic f1_idle();
    f1.EN0 = 1'b0; f1.WE0 = 4'h0; f1.A0 = '0; f1.Di0 = '0;
  endtask

  task automatic f1_write(input logic [8:0] a, input logic [31:0] d);
    @(negedge CLK); f1.EN0 = 1'b1; f1.WE0 = 4'hF; f1.A0 = a; f1.Di0 = d;
    @(negedge CLK); f1_idle();
  endtask

  task automatic f1_read_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
    @(negedge CLK); f1.EN0 = 1'b1; f1.WE0 = 4'h0; f1.A0 = a;
    @(negedge CLK); f1_idle();
    chk(tag, f1.Do0, exp);
  endtask

  // Runs dut1 with junk on the functional port; optional ignored START and mid-run reset.
  task automatic run1(input int pulse_at, input int rst_at, output int cyc);
    @(negedge CLK); START1 = 1'b1;
    @(negedge CLK); START1 = 1'b0;
    chk("busy_after_start", BUSY1, 1'b1);
    chk("done_cleared", DONE1, 1'b0);
    chk("fail_cleared", FAIL1, 1'b0);
    cyc = 1;
    while (cyc < LIMIT) begin
      if (cyc == rst_at) begin RST_N = 1'b0; break; end
      f1.EN0 = 1'b1; f1.WE0 = 4'hF; f1.A0 = 9'($urandom); f1.Di0 = $urandom;
      START1 = (cyc == pulse_at);
      @(negedge CLK);
      if (!BUSY1) break;
      cyc++;
    end
    START1 = 1'b0;
    f1_idle();
  endtask

  initial begin
    int cyc, e_addr, e_elem;
    bit e_fail;
    logic [31:0] e_data;
    logic [8:0]  ra [6];
    logic [31:0] rdat [6];

    f1_idle();
    f2.EN0 = 1'b0; f2.WE0 = '0; f2.A0 = '0; f2.Di0 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY1, 1'b0);
    chk("rst_done", DONE1, 1'b0);
    chk("rst_fail", FAIL1, 1'b0);
    chk("rst_busy2", BUSY2, 1'b0);
`ifdef BIST_FAIL_LOG_EN
    chk("rst_log_addr", FA1, 0);
    chk("rst_log_elem", FE1, 0);
    chk("rst_log_data", FD1, 0);
`endif
    RST_N = 1'b1;

    f1_write(9'h1F0, 32'hF0F0_55BB);
    f1_read_chk("func_1f0", 9'h1F0, 32'hF0F0_55BB);
    chk("func_busy", BUSY1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra[i]   = 9'(i * 64 + int'($urandom_range(0, 63)));
      rdat[i] = $urandom;
      f1_write(ra[i], rdat[i]);
    end
    for (int i = 0; i < 6; i++) f1_read_chk("func_rand", ra[i], rdat[i]);

    // Good RAM, second START at busy cycle 100 must be ignored.
    march_ref(1'b0, 0, 0, 1'b0, e_fail, e_addr, e_elem, e_data);
    run1(100, 0, cyc);
    chk("good_busy_cycles", cyc, BUSY1_EXP);
    chk("good_done", DONE1, 1'b1);
    chk("good_fail", FAIL1, e_fail);
    @(negedge CLK);
    chk("done_sticky", DONE1, 1'b1);
    chk("idle_after_fin", BUSY1, 1'b0);

    // Bit 5 stuck-at-0 at address 0x12.
    fault_en = 1'b1; fault_addr = 'h12; fault_bit = 5; fault_val = 1'b0;
    run1(0, 0, cyc);
    chk("sa0_busy_cycles", cyc, BUSY1_EXP);
    chk("sa0_done", DONE1, 1'b1);
    chk("sa0_fail", FAIL1, 1'b1);
`ifdef BIST_FAIL_LOG_EN
    chk("sa0_log_addr", FA1, 9'h012);
    chk("sa0_log_elem", FE1, 3'd2);
    chk("sa0_log_data", FD1, 32'hFFFF_FFDF);
`endif

    // Random stuck-at cell checked against the array reference.
    fault_addr = int'($urandom_range(0, DEPTH1 - 1));
    fault_bit  = int'($urandom_range(0, 31));
    fault_val  = 1'($urandom_range(0, 1));
    march_ref(1'b1, fault_addr, fault_bit, fault_val, e_fail, e_addr, e_elem, e_data);
    run1(0, 0, cyc);
    chk("rnd_busy_cycles", cyc, BUSY1_EXP);
    chk("rnd_done", DONE1, 1'b1);
    chk("rnd_fail", FAIL1, e_fail);
`ifdef BIST_FAIL_LOG_EN
    chk("rnd_log_addr", FA1, e_addr);
    chk("rnd_log_elem", FE1, e_elem);
    chk("rnd_log_data", FD1, e_data);
`endif

    // Reset in the middle of a run.
    fault_en = 1'b0;
    run1(0, 3000, cyc);
    chk("abort_at", cyc, 3000);
    #1;
    chk("abort_busy", BUSY1, 1'b0);
    chk("abort_done", DONE1, 1'b0);
    chk("abort_fail", FAIL1, 1'b0);
`ifdef BIST_FAIL_LOG_EN
    chk("abort_log_addr", FA1, 0);
`endif
    @(negedge CLK); RST_N = 1'b1;
    ra[0] = 9'($urandom); rdat[0] = $urandom;
    f1_write(ra[0], rdat[0]);
    f1_read_chk("func_after_abort", ra[0], rdat[0]);

    march_ref(1'b0, 0, 0, 1'b0, e_fail, e_addr, e_elem, e_data);
    run1(0, 0, cyc);
    chk("rerun_busy_cycles", cyc, BUSY1_EXP);
    chk("rerun_done", DONE1, 1'b1);
    chk("rerun_fail", FAIL1, e_fail);

    // Small configuration with read latency 2; START in the DONE-rise cycle is ignored.
    @(negedge CLK); START2 = 1'b1;
    @(negedge CLK); START2 = 1'b0;
    chk("cfg2_busy_after_start", BUSY2, 1'b1);
    cyc = 1;
    while (cyc < LIMIT) begin
      @(negedge CLK);
      if (!BUSY2) break;
      cyc++;
    end
    chk("cfg2_busy_cycles", cyc, BUSY2_EXP);
    chk("cfg2_done", DONE2, 1'b1);
    chk("cfg2_fail", FAIL2, 1'b0);
    START2 = 1'b1;
    @(negedge CLK); START2 = 1'b0;
    chk("cfg2_start_at_fin_busy", BUSY2, 1'b0);
    chk("cfg2_start_at_fin_done", DONE2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
